// File: rtl/sccb_slave_responder.sv
// sccb_slave_responder
//   Oversampled SCCB/I2C slave for OV5647-style transfers:
//     write: ID, addr-hi, addr-lo, data... (burst, auto-increment)
//     read : ID|1, data... (master acks to continue, nacks to finish)
//   SIOC/SIOD are synchronised to clk and edges are detected from a history flop.
//   A 16-bit address pointer / 8-bit data register port faces the register bank.
module sccb_slave_responder #(
  parameter logic [7:0] SID         = 8'h6C,
  parameter bit         ACK_EN      = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resend,
  input  logic        sioc_i,
  input  logic        siod_i,
  output logic        siod_oe,
  output logic        busy,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  output logic        rd_strobe,
  input  logic [7:0]  rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV,
    S_AH,
    S_AL,
    S_WD,
    S_RD,
    S_IGNORE
  } state_t;

  // Synchronizer chains plus one history flop per pin
  logic [SYNC_STAGES-1:0] sioc_sync_reg;
  logic [SYNC_STAGES-1:0] siod_sync_reg;
  logic                   sioc_hist_reg;
  logic                   siod_hist_reg;

  // Protocol state
  state_t      state_reg;
  logic [3:0]  bit_cnt_reg;    // SIOC rising edges seen in the current 9-bit frame
  logic [6:0]  shift_reg;      // received bits; the 8th bit is taken straight from the pin
  logic [6:0]  tx_reg;         // remaining bits of the byte being returned to the master
  logic [15:0] ptr_reg;
  logic        load_pend_reg;  // rd_data is valid this cycle, load it into the TX shifter
  logic        siod_oe_reg;
  logic        busy_reg;
  logic        wr_en_reg;
  logic [15:0] wr_addr_reg;
  logic [7:0]  wr_data_reg;
  logic        rd_strobe_reg;

  logic       sioc_s;
  logic       siod_s;
  logic       sioc_rise;
  logic       sioc_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;

  assign sioc_s    = sioc_sync_reg[SYNC_STAGES-1];
  assign siod_s    = siod_sync_reg[SYNC_STAGES-1];
  assign sioc_rise = sioc_s & ~sioc_hist_reg;
  assign sioc_fall = ~sioc_s & sioc_hist_reg;
  // START/STOP need SIOC stable high across both samples so data moves under SIOC low never qualify
  assign start_det = sioc_s & sioc_hist_reg & siod_hist_reg & ~siod_s;
  assign stop_det  = sioc_s & sioc_hist_reg & ~siod_hist_reg & siod_s;
  assign rx_byte   = {shift_reg, siod_s};

  assign siod_oe   = siod_oe_reg;
  assign busy      = busy_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign rd_addr   = ptr_reg;
  assign rd_strobe = rd_strobe_reg;

  // Bring SIOC/SIOD into the clk domain; idle-high reset value matches a released bus
  always_ff @(posedge clk) begin
    if (resend) begin
      sioc_sync_reg <= '1;
      siod_sync_reg <= '1;
      sioc_hist_reg <= 1'b1;
      siod_hist_reg <= 1'b1;
    end else begin
      sioc_sync_reg <= {sioc_sync_reg[SYNC_STAGES-2:0], sioc_i};
      siod_sync_reg <= {siod_sync_reg[SYNC_STAGES-2:0], siod_i};
      sioc_hist_reg <= sioc_s;
      siod_hist_reg <= siod_s;
    end
  end

  // Protocol FSM: sample on SIOC rise, drive SIOD on SIOC fall, START/STOP override everything
  always_ff @(posedge clk) begin
    if (resend) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 7'd0;
      tx_reg        <= 7'd0;
      ptr_reg       <= 16'd0;
      load_pend_reg <= 1'b0;
      siod_oe_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= 16'd0;
      wr_data_reg   <= 8'd0;
      rd_strobe_reg <= 1'b0;
    end else begin
      wr_en_reg     <= 1'b0;
      rd_strobe_reg <= 1'b0;

      // rd_data answers the strobe one cycle later; MSB goes straight onto the line
      if (load_pend_reg) begin
        tx_reg        <= rd_data[6:0];
        siod_oe_reg   <= ~rd_data[7];
        load_pend_reg <= 1'b0;
      end

      if (stop_det) begin
        state_reg     <= S_IDLE;
        busy_reg      <= 1'b0;
        siod_oe_reg   <= 1'b0;
        bit_cnt_reg   <= 4'd0;
        load_pend_reg <= 1'b0;
      end else if (start_det) begin
        // Pointer is deliberately kept so a read can follow a pointer-setting write
        state_reg     <= S_DEV;
        busy_reg      <= 1'b1;
        siod_oe_reg   <= 1'b0;
        bit_cnt_reg   <= 4'd0;
        load_pend_reg <= 1'b0;
      end else if (sioc_rise) begin
        case (state_reg)
          S_DEV, S_AH, S_AL, S_WD: begin
            if (bit_cnt_reg != 4'd8) begin
              shift_reg   <= rx_byte[6:0];
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                case (state_reg)
                  S_DEV: begin
                    if (rx_byte[7:1] != SID[7:1]) state_reg <= S_IGNORE;
                  end
                  S_AH: ptr_reg[15:8] <= rx_byte;
                  S_AL: ptr_reg[7:0]  <= rx_byte;
                  S_WD: begin
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= ptr_reg;
                    wr_data_reg <= rx_byte;
                    ptr_reg     <= ptr_reg + 16'd1;
                  end
                  default: ;
                endcase
              end
            end else begin
              // 9th rise closes the ack slot; shift_reg[0] still holds the R/W bit
              bit_cnt_reg <= 4'd0;
              case (state_reg)
                S_DEV:   state_reg <= shift_reg[0] ? S_RD : S_AH;
                S_AH:    state_reg <= S_AL;
                S_AL:    state_reg <= S_WD;
                default: ;
              endcase
            end
          end
          S_RD: begin
            if (bit_cnt_reg != 4'd8) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (!siod_s) begin
              ptr_reg     <= ptr_reg + 16'd1;
              bit_cnt_reg <= 4'd0;
            end else begin
              state_reg <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (sioc_fall) begin
        case (state_reg)
          S_DEV, S_AH, S_AL, S_WD: begin
            if (bit_cnt_reg == 4'd8) siod_oe_reg <= ACK_EN;
            else if (bit_cnt_reg == 4'd0) siod_oe_reg <= 1'b0;
          end
          S_RD: begin
            if (bit_cnt_reg == 4'd0) begin
              rd_strobe_reg <= 1'b1;
              load_pend_reg <= 1'b1;
              siod_oe_reg   <= 1'b0;
            end else if (bit_cnt_reg == 4'd8) begin
              siod_oe_reg <= 1'b0;
            end else begin
              siod_oe_reg <= ~tx_reg[6];
              tx_reg      <= {tx_reg[5:0], 1'b0};
            end
          end
          default: siod_oe_reg <= 1'b0;
        endcase
      end
    end
  end

endmodule
